// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over back-to-back GATE_CYCLES windows.
// Define FREQ_METER_BCD_EN to add a sequential double-dabble converter driving bcd/bcd_valid.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic [31:0]      bcd,
    output logic             bcd_valid
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic {IDLE, GATE} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             edge_det;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, cnt_nxt;
    logic             win_ovf, ovf_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    // Saturating increment; an edge arriving at all-ones marks the window as overflowed.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = win_ovf;
        if (edge_det) begin
            if (&edge_cnt) ovf_nxt = 1'b1;
            else           cnt_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            win_ovf    <= 1'b0;
            freq       <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    win_ovf  <= 1'b0;
                    if (en) state <= GATE;
                end
                GATE: begin
                    if (!en) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        win_ovf  <= 1'b0;
                    end else if (gate_cnt == LAST) begin
                        // Closing cycle: its own edge is folded in, next window starts clean.
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        win_ovf    <= 1'b0;
                        freq       <= cnt_nxt;
                        overflow   <= ovf_nxt;
                        freq_valid <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        edge_cnt <= cnt_nxt;
                        win_ovf  <= ovf_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FREQ_METER_BCD_EN
    // Scratch holds at least 9 digits so out-of-range counts are detectable.
    localparam int ND0 = (CNT_W * 31) / 100 + 1;
    localparam int ND  = (ND0 > 9) ? ND0 : 9;
    localparam int SW  = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] bin_sh;
    logic [4*ND-1:0]  dd_sh, dd_add, dd_nxt;
    logic [SW-1:0]    step;
    logic             busy, sat_ovf;

    always_comb begin
        dd_add = dd_sh;
        for (int d = 0; d < ND; d++) begin
            if (dd_sh[4*d +: 4] >= 4'd5) dd_add[4*d +: 4] = dd_sh[4*d +: 4] + 4'd3;
        end
        dd_nxt = {dd_add[4*ND-2:0], bin_sh[CNT_W-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sh    <= '0;
            dd_sh     <= '0;
            step      <= '0;
            busy      <= 1'b0;
            sat_ovf   <= 1'b0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (freq_valid) begin
                bin_sh  <= freq;
                dd_sh   <= '0;
                step    <= '0;
                busy    <= 1'b1;
                sat_ovf <= overflow;
            end else if (busy) begin
                bin_sh <= bin_sh << 1;
                dd_sh  <= dd_nxt;
                step   <= step + SW'(1);
                if (step == SW'(CNT_W - 1)) begin
                    busy      <= 1'b0;
                    bcd_valid <= 1'b1;
                    bcd       <= (sat_ovf || (|{dd_add[4*ND-1], dd_nxt[4*ND-1:32]}))
                                 ? 32'h9999_9999 : dd_nxt[31:0];
                end
            end
        end
    end
`else
    assign bcd       = '0;
    assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: one 27-bit instance and one 4-bit instance for saturation.
module tb_freq_meter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, sig_a = 1'b0, en_b = 1'b0, sig_b = 1'b0;
    logic [26:0] freq_a;
    logic [3:0]  freq_b;
    logic        fv_a, ov_a, bv_a, fv_b, ov_b, bv_b;
    logic [31:0] bcd_a, bcd_b;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(27)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_a), .freq(freq_a),
        .freq_valid(fv_a), .overflow(ov_a), .bcd(bcd_a), .bcd_valid(bv_a));

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_b), .freq(freq_b),
        .freq_valid(fv_b), .overflow(ov_b), .bcd(bcd_b), .bcd_valid(bv_b));

    int errors = 0, checks = 0, cyc = 0;
    int per_a = 0, ph_a = 0, per_b = 0, ph_b = 0;
    int fv_cnt_a = 0, fv_cyc_a = -1, bv_cnt_a = 0, bv_cyc_a = -1;
    int fv_cnt_b = 0, fv_cyc_b = -1, bv_cnt_b = 0, bv_cyc_b = -1;

    // One clock: advance periodic stimulus just after the edge, observe on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (per_a != 0) begin ph_a = (ph_a + 1) % per_a; sig_a = (ph_a < per_a / 2); end
        if (per_b != 0) begin ph_b = (ph_b + 1) % per_b; sig_b = (ph_b < per_b / 2); end
        @(negedge clk);
        if (fv_a) begin fv_cnt_a++; fv_cyc_a = cyc; end
        if (bv_a) begin bv_cnt_a++; bv_cyc_a = cyc; end
        if (fv_b) begin fv_cnt_b++; fv_cyc_b = cyc; end
        if (bv_b) begin bv_cnt_b++; bv_cyc_b = cyc; end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        en_a = 1'b1;
        steps(3);
        checks++; if (freq_a !== 27'd0) begin errors++; $display("FAIL reset_freq: got %0d want 0", freq_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ov_a); end
        checks++; if (bcd_a !== 32'd0 || bv_a !== 1'b0) begin errors++; $display("FAIL reset_bcd: got %h/%b want 0/0", bcd_a, bv_a); end
        checks++; if (fv_cnt_a != 0 || freq_b !== 4'd0) begin errors++; $display("FAIL reset_valid: fv_cnt %0d freq_b %0d want 0/0", fv_cnt_a, freq_b); end
        en_a = 1'b0;
        rst  = 1'b1;
        steps(2);
    endtask

    task automatic test_period10();
        int c;
        per_a = 10;
        steps(20);
        c = cyc;
        en_a = 1'b1;
        steps(101);
        checks++; if (fv_cyc_a != c + 101 || fv_cnt_a != 1) begin errors++; $display("FAIL first_window_latency: cyc %0d cnt %0d want %0d/1", fv_cyc_a - c, fv_cnt_a, 101); end
        steps(100);
        checks++; if (fv_cyc_a != c + 201 || fv_cnt_a != 2) begin errors++; $display("FAIL window_period: cyc %0d cnt %0d want 201/2", fv_cyc_a - c, fv_cnt_a); end
        checks++; if (freq_a !== 27'd10) begin errors++; $display("FAIL period10_freq: got %0d want 10", freq_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL period10_ovf: got %b want 0", ov_a); end
        step();
        checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b want 0", fv_a); end
        steps(27);
`ifdef FREQ_METER_BCD_EN
        checks++; if (bv_cyc_a != c + 229 || bcd_a !== 32'h0000_0010) begin errors++; $display("FAIL bcd_10: cyc %0d bcd %h want 229/00000010", bv_cyc_a - c, bcd_a); end
`else
        checks++; if (bcd_a !== 32'd0 || bv_cnt_a != 0) begin errors++; $display("FAIL bcd_disabled: bcd %h pulses %0d want 0/0", bcd_a, bv_cnt_a); end
`endif
        steps(72);
        checks++; if (fv_cyc_a != c + 301 || freq_a !== 27'd10) begin errors++; $display("FAIL third_window: cyc %0d freq %0d want 301/10", fv_cyc_a - c, freq_a); end
        en_a = 1'b0;
        steps(5);
        checks++; if (freq_a !== 27'd10 || fv_cnt_a != 3) begin errors++; $display("FAIL idle_hold: freq %0d cnt %0d want 10/3", freq_a, fv_cnt_a); end
    endtask

    task automatic test_edge_at_last();
        int c;
        per_a = 0;
        sig_a = 1'b0;
        steps(5);
        c = cyc;
        en_a = 1'b1;
        steps(98);
        sig_a = 1'b1;          // detected at gate_cnt == 99
        steps(3);
        checks++; if (fv_cyc_a != c + 101 || freq_a !== 27'd1) begin errors++; $display("FAIL edge_last_counted: cyc %0d freq %0d want 101/1", fv_cyc_a - c, freq_a); end
        steps(49);
        sig_a = 1'b0;
        steps(49);
        sig_a = 1'b1;          // detected at gate_cnt == 0 of the third window
        steps(2);
        checks++; if (fv_cyc_a != c + 201 || freq_a !== 27'd0) begin errors++; $display("FAIL edge_last_excluded: cyc %0d freq %0d want 201/0", fv_cyc_a - c, freq_a); end
        steps(100);
        checks++; if (fv_cyc_a != c + 301 || freq_a !== 27'd1) begin errors++; $display("FAIL edge_first_counted: cyc %0d freq %0d want 301/1", fv_cyc_a - c, freq_a); end
        en_a = 1'b0;
    endtask

    task automatic test_abort();
        int c, n0;
        per_a = 10;
        steps(30);
        c = cyc;
        n0 = fv_cnt_a;
        en_a = 1'b1;
        steps(51);
        en_a = 1'b0;           // sampled while gate_cnt == 50
        steps(20);
        en_a = 1'b1;
        steps(100);
        checks++; if (fv_cnt_a != n0) begin errors++; $display("FAIL abort_no_publish: pulses %0d want %0d", fv_cnt_a, n0); end
        step();
        checks++; if (fv_cyc_a != c + 172 || freq_a !== 27'd10) begin errors++; $display("FAIL abort_next_full: cyc %0d freq %0d want 172/10", fv_cyc_a - c, freq_a); end
    endtask

    task automatic test_reset_mid();
        int r, n0;
        steps(40);
        rst = 1'b0;
        #1;
        checks++; if (freq_a !== 27'd0 || ov_a !== 1'b0 || fv_a !== 1'b0 || bcd_a !== 32'd0 || bv_a !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs: freq %0d ovf %b fv %b bcd %h bv %b want all 0", freq_a, ov_a, fv_a, bcd_a, bv_a);
        end
        n0 = fv_cnt_a;
        steps(3);
        rst = 1'b1;
        r = cyc;
        steps(100);
        checks++; if (fv_cnt_a != n0) begin errors++; $display("FAIL reset_no_partial: pulses %0d want %0d", fv_cnt_a, n0); end
        step();
        checks++; if (fv_cyc_a != r + 101 || freq_a !== 27'd10) begin errors++; $display("FAIL reset_restart: cyc %0d freq %0d want 101/10", fv_cyc_a - r, freq_a); end
        en_a = 1'b0;
        per_a = 0;
    endtask

    task automatic test_saturate();
        int c;
        per_b = 2;
        steps(10);
        c = cyc;
        en_b = 1'b1;
        steps(101);
        checks++; if (fv_cyc_b != c + 101 || freq_b !== 4'd15) begin errors++; $display("FAIL sat_freq: cyc %0d freq %0d want 101/15", fv_cyc_b - c, freq_b); end
        checks++; if (ov_b !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", ov_b); end
        steps(5);
`ifdef FREQ_METER_BCD_EN
        checks++; if (bv_cyc_b != c + 106 || bcd_b !== 32'h9999_9999) begin errors++; $display("FAIL sat_bcd: cyc %0d bcd %h want 106/99999999", bv_cyc_b - c, bcd_b); end
`else
        checks++; if (bcd_b !== 32'd0 || bv_cnt_b != 0) begin errors++; $display("FAIL sat_bcd_disabled: bcd %h pulses %0d want 0/0", bcd_b, bv_cnt_b); end
`endif
        en_b = 1'b0;
        per_b = 0;
    endtask

    initial begin
        test_reset();
        test_period10();
        test_edge_at_last();
        test_abort();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
